// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for SB/SH stores; SW is written directly.
// Optional misalignment check enabled by defining STORE_RMW_ALIGN_CHECK_EN.
module store_rmw_ctrl #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_b,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   output logic [31:0]       mdr_q,
   output logic [31:0]       b_q,
   output logic              ss_command,
   input  logic [31:0]       ss_data,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_WRITE   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [1:0] OP_SB = 2'b00;
   localparam logic [1:0] OP_SH = 2'b01;
   localparam logic [1:0] OP_SW = 2'b10;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   logic [2:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-3:0] addr_q, addr_d;
   logic [1:0]        op_q, op_d;
   logic [31:0]       mdr_d, b_d;
   logic              cmd_q, cmd_d;
   logic              rd_q, wr_q, done_q, err_q, ready_q;
   logic              err_d;
   logic              misalign_s;

`ifdef STORE_RMW_ALIGN_CHECK_EN
   assign misalign_s = ((req_op == OP_SH) && req_addr[0]) ||
                       ((req_op == OP_SW) && (req_addr[1:0] != 2'b00));
`else
   // Low address bits only matter to the alignment check.
   logic unused_addr_lsb_s;
   assign misalign_s        = 1'b0;
   assign unused_addr_lsb_s = ^req_addr[1:0];
`endif

   // Next-state and datapath register update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      mdr_d   = mdr_q;
      b_d     = b_q;
      cmd_d   = cmd_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d = req_addr[ADDR_W-1:2];
               b_d    = req_b;
               op_d   = req_op;
               cmd_d  = req_op[0];
               cnt_d  = LAT_M1;
               if (misalign_s) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  case (req_op)
                     OP_SB, OP_SH: state_d = S_READ;
                     OP_SW:        state_d = S_WRITE;
                     default:      state_d = S_DONE;
                  endcase
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            if (cnt_q == 4'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_CAPTURE: begin
            mdr_d   = mem_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and strobe registers; strobes decode the next state so they are flop outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         op_q    <= 2'b00;
         mdr_q   <= 32'h0000_0000;
         b_q     <= 32'h0000_0000;
         cmd_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         mdr_q   <= mdr_d;
         b_q     <= b_d;
         cmd_q   <= cmd_d;
         rd_q    <= (state_d == S_READ);
         wr_q    <= (state_d == S_WRITE);
         done_q  <= (state_d == S_DONE);
         err_q   <= err_d;
         ready_q <= (state_d == S_IDLE);
      end
   end

   assign req_ready  = ready_q;
   assign mem_addr   = {addr_q, 2'b00};
   assign mem_rd     = rd_q;
   assign mem_wr     = wr_q;
   // Merged word arrives combinationally from the merge unit while in WRITE.
   assign mem_wdata  = (op_q == OP_SW) ? b_q : ss_data;
   assign ss_command = cmd_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (MEM_LATENCY 1 and 3) share the request inputs.
module tb_store_rmw_ctrl;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] b;
      bit          rd;
      bit          wr;
      bit          err;
      logic [31:0] wdata;
      logic [31:0] waddr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'b00;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_b = 32'h0;

   logic        req_ready_s [2];
   logic [31:0] mem_addr_s  [2];
   logic        mem_rd_s    [2];
   logic [31:0] mem_rdata_s [2];
   logic        mem_wr_s    [2];
   logic [31:0] mem_wdata_s [2];
   logic [31:0] mdr_q_s     [2];
   logic [31:0] b_q_s       [2];
   logic        ss_cmd_s    [2];
   logic [31:0] ss_data_s   [2];
   logic        done_s      [2];
   logic        err_s       [2];
   int          rdcnt       [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_rmw_ctrl #(.MEM_LATENCY(1), .ADDR_W(32)) u_lat1 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_s[0]),
      .req_op(req_op), .req_addr(req_addr), .req_b(req_b), .mem_addr(mem_addr_s[0]),
      .mem_rd(mem_rd_s[0]), .mem_rdata(mem_rdata_s[0]), .mem_wr(mem_wr_s[0]),
      .mem_wdata(mem_wdata_s[0]), .mdr_q(mdr_q_s[0]), .b_q(b_q_s[0]),
      .ss_command(ss_cmd_s[0]), .ss_data(ss_data_s[0]), .done(done_s[0]), .err(err_s[0])
   );

   store_rmw_ctrl #(.MEM_LATENCY(3), .ADDR_W(32)) u_lat3 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_s[1]),
      .req_op(req_op), .req_addr(req_addr), .req_b(req_b), .mem_addr(mem_addr_s[1]),
      .mem_rd(mem_rd_s[1]), .mem_rdata(mem_rdata_s[1]), .mem_wr(mem_wr_s[1]),
      .mem_wdata(mem_wdata_s[1]), .mdr_q(mdr_q_s[1]), .b_q(b_q_s[1]),
      .ss_command(ss_cmd_s[1]), .ss_data(ss_data_s[1]), .done(done_s[1]), .err(err_s[1])
   );

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0104: return 32'h1122_3344;
         32'h0000_0208: return 32'hCAFE_0000;
         default:       return 32'h0BAD_F00D;
      endcase
   endfunction

   // Merge-unit stub and a memory whose data is only valid after mem_rd was held long enough.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         ss_data_s[k] = ss_cmd_s[k] ? {mdr_q_s[k][31:16], b_q_s[k][15:0]}
                                    : {mdr_q_s[k][31:8],  b_q_s[k][7:0]};
         mem_rdata_s[k] = (rdcnt[k] >= lat(k)) ? mem_word(mem_addr_s[k]) : 32'hDEAD_DEAD;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         rdcnt[k] <= mem_rd_s[k] ? rdcnt[k] + 1 : 0;
      end
   end

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%h required=%h", name, k, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int rd_first [2];
      int rd_n [2];
      int wr_cyc [2];
      int wr_n [2];
      int done_cyc [2];
      int done_n [2];
      int err_cyc [2];
      int both [2];
      logic [31:0] wd [2];
      logic [31:0] wa [2];
      logic        cmd [2];
      int exp_wr;
      for (int k = 0; k < 2; k++) begin
         rd_first[k] = -1; rd_n[k] = 0; wr_cyc[k] = -1; wr_n[k] = 0;
         done_cyc[k] = -1; done_n[k] = 0; err_cyc[k] = -1; both[k] = 0;
         wd[k] = 32'h0; wa[k] = 32'h0; cmd[k] = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) check($sformatf("v%0d_ready", idx), k, {31'h0, req_ready_s[k]}, 32'h1);
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_b = v.b;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 2'b10; req_addr = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (mem_rd_s[k]) begin
               if (rd_first[k] < 0) rd_first[k] = cyc;
               rd_n[k]++;
            end
            if (mem_wr_s[k]) begin
               wr_cyc[k] = cyc; wr_n[k]++;
               wd[k] = mem_wdata_s[k]; wa[k] = mem_addr_s[k]; cmd[k] = ss_cmd_s[k];
            end
            if (done_s[k]) begin done_cyc[k] = cyc; done_n[k]++; end
            if (err_s[k]) err_cyc[k] = cyc;
            if (mem_rd_s[k] && mem_wr_s[k]) both[k]++;
         end
      end
      for (int k = 0; k < 2; k++) begin
         exp_wr = v.rd ? lat(k) + 2 : (v.wr ? 1 : -1);
         check($sformatf("v%0d_rd_first", idx), k, rd_first[k], v.rd ? 1 : -1);
         check($sformatf("v%0d_rd_len", idx), k, rd_n[k], v.rd ? lat(k) : 0);
         check($sformatf("v%0d_wr_cycle", idx), k, wr_cyc[k], exp_wr);
         check($sformatf("v%0d_wr_count", idx), k, wr_n[k], v.wr ? 1 : 0);
         check($sformatf("v%0d_done_cycle", idx), k, done_cyc[k], v.wr ? exp_wr + 1 : 1);
         check($sformatf("v%0d_done_count", idx), k, done_n[k], 1);
         check($sformatf("v%0d_err_cycle", idx), k, err_cyc[k], v.err ? 1 : -1);
         check($sformatf("v%0d_rd_wr_overlap", idx), k, both[k], 0);
         if (v.wr) begin
            check($sformatf("v%0d_wdata", idx), k, wd[k], v.wdata);
            check($sformatf("v%0d_waddr", idx), k, wa[k], v.waddr);
            check($sformatf("v%0d_ss_command", idx), k, {31'h0, cmd[k]}, {31'h0, v.op[0]});
         end
      end
   endtask

   initial begin
      vec_t vecs [8];
      int   acc [2][2];
      int   nacc [2];
      int   ready_in_done [2];
      int   bad [2];

      vecs[0] = '{op: 2'b00, addr: 32'h104, b: 32'hAABB_CCDD, rd: 1'b1, wr: 1'b1, err: 1'b0, wdata: 32'h1122_33DD, waddr: 32'h104};
      vecs[1] = '{op: 2'b01, addr: 32'h20A, b: 32'h0000_BEEF, rd: 1'b1, wr: 1'b1, err: 1'b0, wdata: 32'hCAFE_BEEF, waddr: 32'h208};
      vecs[2] = '{op: 2'b10, addr: 32'h040, b: 32'h1234_5678, rd: 1'b0, wr: 1'b1, err: 1'b0, wdata: 32'h1234_5678, waddr: 32'h040};
      vecs[3] = '{op: 2'b00, addr: 32'h20B, b: 32'h0000_0077, rd: 1'b1, wr: 1'b1, err: 1'b0, wdata: 32'hCAFE_0077, waddr: 32'h208};
      vecs[4] = '{op: 2'b11, addr: 32'h104, b: 32'h5555_5555, rd: 1'b0, wr: 1'b0, err: 1'b0, wdata: 32'h0, waddr: 32'h0};
      vecs[5] = '{op: 2'b00, addr: 32'h103, b: 32'h0000_0012, rd: 1'b1, wr: 1'b1, err: 1'b0, wdata: 32'h0BAD_F012, waddr: 32'h100};
`ifdef STORE_RMW_ALIGN_CHECK_EN
      vecs[6] = '{op: 2'b01, addr: 32'h101, b: 32'h0000_BEEF, rd: 1'b0, wr: 1'b0, err: 1'b1, wdata: 32'h0, waddr: 32'h0};
      vecs[7] = '{op: 2'b10, addr: 32'h043, b: 32'hA5A5_A5A5, rd: 1'b0, wr: 1'b0, err: 1'b1, wdata: 32'h0, waddr: 32'h0};
`else
      vecs[6] = '{op: 2'b01, addr: 32'h101, b: 32'h0000_BEEF, rd: 1'b1, wr: 1'b1, err: 1'b0, wdata: 32'h0BAD_BEEF, waddr: 32'h100};
      vecs[7] = '{op: 2'b10, addr: 32'h043, b: 32'hA5A5_A5A5, rd: 1'b0, wr: 1'b1, err: 1'b0, wdata: 32'hA5A5_A5A5, waddr: 32'h040};
`endif

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_ready", k, {31'h0, req_ready_s[k]}, 32'h1);
         check("rst_strobes", k, {28'h0, mem_rd_s[k], mem_wr_s[k], done_s[k], err_s[k]}, 32'h0);
         check("rst_mdr", k, mdr_q_s[k], 32'h0);
         check("rst_b", k, b_q_s[k], 32'h0);
         check("rst_ss_command", k, {31'h0, ss_cmd_s[k]}, 32'h0);
      end

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // req_valid held high: next accept only after DONE, never during it.
      for (int k = 0; k < 2; k++) begin nacc[k] = 0; ready_in_done[k] = 0; end
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h104; req_b = 32'h0000_00EE;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (req_ready_s[k] && nacc[k] < 2) begin acc[k][nacc[k]] = c; nacc[k]++; end
            if (req_ready_s[k] && done_s[k]) ready_in_done[k]++;
         end
      end
      req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("b2b_accepts", k, nacc[k], 2);
         check("b2b_first", k, acc[k][0], 0);
         check("b2b_second", k, acc[k][1], lat(k) + 4);
         check("b2b_ready_in_done", k, ready_in_done[k], 0);
      end
      repeat (12) @(negedge clk);

      // Reset during READ aborts with no write and no done.
      for (int k = 0; k < 2; k++) bad[k] = 0;
      req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h208; req_b = 32'h0000_0011;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) check("abort_in_read", k, {31'h0, mem_rd_s[k]}, 32'h1);
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) check("abort_rd_drop", k, {31'h0, mem_rd_s[k]}, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) if (mem_wr_s[k] || done_s[k]) bad[k]++;
      end
      reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("abort_ready", k, {31'h0, req_ready_s[k]}, 32'h1);
         check("abort_mdr", k, mdr_q_s[k], 32'h0);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) if (mem_wr_s[k] || done_s[k] || mem_rd_s[k]) bad[k]++;
      end
      for (int k = 0; k < 2; k++) check("abort_quiet", k, bad[k], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
